// File: rtl/mpmc9_read_return.sv
// mpmc9_read_return
// Matches the single PHY read-data stream to the channel that issued each
// read. Read tags (channel + beat count) are queued in order at command issue;
// every data beat is steered into the head tag's channel holding register with
// a one-cycle acknowledge pulse, and the tag retires after its last beat.
//
// Ports:
//   clk, rstn            memory UI clock, asynchronous active-low reset
//   tag_wr/tag_ch/tag_beats  push a read tag (beats field = beats - 1)
//   tag_full, outstanding    registered FIFO status after this cycle's push/pop
//   rd_valid, rd_data        128-bit read beat from the PHY, no backpressure
//   ch_rdat, ch_ack          eight 128-bit holding registers + per-channel pulse
//   err_clr                  clears the sticky error flags
//   err_ovf/err_orphan/err_tmo  sticky: push while full / beat with no tag /
//                               tag discarded by idle timeout
//
// Optional build macro: MPMC9_RRET_TIMEOUT_EN enables the idle-timeout tag
// discard; without it err_tmo is constant 0.
module mpmc9_read_return #(
    parameter int TAG_DEPTH = 16,
    parameter int TMO_CYC   = 1023
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         tag_wr,
    input  logic [2:0]                   tag_ch,
    input  logic [1:0]                   tag_beats,
    output logic                         tag_full,
    input  logic                         rd_valid,
    input  logic [127:0]                 rd_data,
    output logic [1023:0]                ch_rdat,
    output logic [7:0]                   ch_ack,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    input  logic                         err_clr,
    output logic                         err_ovf,
    output logic                         err_orphan,
    output logic                         err_tmo
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [4:0]            tag_mem_r [TAG_DEPTH];
    logic [AW:0]           wr_ptr_r, rd_ptr_r;
    logic [AW:0]           wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [1:0]            beat_cnt_r;
    logic [7:0][127:0]     ch_rdat_r;
    logic [7:0]            ch_ack_r;
    logic [AW:0]           outstanding_r;
    logic                  tag_full_r;
    logic                  err_ovf_r, err_orphan_r, err_tmo_r;

    logic                  empty_s, full_s, push_s, beat_s, pop_s, tmo_pop_s;
    logic [4:0]            head_s;
    logic [2:0]            head_ch_s;
    logic [1:0]            head_beats_s;

    // FIFO status, head tag decode and push/pop qualification
    always_comb begin
        empty_s      = (wr_ptr_r == rd_ptr_r);
        full_s       = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                       (wr_ptr_r[AW] != rd_ptr_r[AW]);
        head_s       = tag_mem_r[rd_ptr_r[AW-1:0]];
        head_ch_s    = head_s[4:2];
        head_beats_s = head_s[1:0];
        // A push while full is dropped even when a pop frees a slot this cycle
        push_s       = tag_wr & ~full_s;
        // Beats only consume existing tags; a same-cycle push never bypasses
        beat_s       = rd_valid & ~empty_s;
        pop_s        = (beat_s & (beat_cnt_r == head_beats_s)) | tmo_pop_s;
    end

    // Next pointer values, used for the registered occupancy/full outputs
    always_comb begin
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Tag storage: write the pushed tag at the write index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= 5'd0;
            end
        end else if (push_s) begin
            tag_mem_r[wr_ptr_r[AW-1:0]] <= {tag_ch, tag_beats};
        end else begin
            tag_mem_r <= tag_mem_r;
        end
    end

    // Pointers, beat counter and registered FIFO status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            beat_cnt_r    <= 2'd0;
            outstanding_r <= '0;
            tag_full_r    <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            outstanding_r <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            tag_full_r    <= (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                             (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]);
            // Retiring a tag (last beat or timeout) restarts the beat count
            if (pop_s) begin
                beat_cnt_r <= 2'd0;
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + 2'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    // Holding registers and acknowledge pulse for the head tag's channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_rdat_r <= '0;
            ch_ack_r  <= 8'd0;
        end else if (beat_s) begin
            ch_rdat_r[head_ch_s] <= rd_data;
            ch_ack_r             <= 8'd1 << head_ch_s;
        end else begin
            ch_ack_r <= 8'd0;
        end
    end

    // Sticky error flags; a new error outranks a same-cycle clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf_r    <= 1'b0;
            err_orphan_r <= 1'b0;
        end else begin
            if (tag_wr && full_s) begin
                err_ovf_r <= 1'b1;
            end else if (err_clr) begin
                err_ovf_r <= 1'b0;
            end else begin
                err_ovf_r <= err_ovf_r;
            end
            if (rd_valid && empty_s) begin
                err_orphan_r <= 1'b1;
            end else if (err_clr) begin
                err_orphan_r <= 1'b0;
            end else begin
                err_orphan_r <= err_orphan_r;
            end
        end
    end

`ifdef MPMC9_RRET_TIMEOUT_EN
    logic [15:0] idle_cnt_r;

    // Timeout fires on the TMO_CYC-th consecutive idle cycle with tags pending
    always_comb begin
        tmo_pop_s = ~empty_s & ~rd_valid & (idle_cnt_r == 16'(TMO_CYC - 1));
    end

    // Idle counter and sticky timeout flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt_r <= 16'd0;
            err_tmo_r  <= 1'b0;
        end else begin
            if (rd_valid || empty_s || tmo_pop_s) begin
                idle_cnt_r <= 16'd0;
            end else begin
                idle_cnt_r <= idle_cnt_r + 16'd1;
            end
            if (tmo_pop_s) begin
                err_tmo_r <= 1'b1;
            end else if (err_clr) begin
                err_tmo_r <= 1'b0;
            end else begin
                err_tmo_r <= err_tmo_r;
            end
        end
    end
`else
    assign tmo_pop_s = 1'b0;
    assign err_tmo_r = 1'b0;
`endif

    assign tag_full    = tag_full_r;
    assign outstanding = outstanding_r;
    assign ch_rdat     = ch_rdat_r;
    assign ch_ack      = ch_ack_r;
    assign err_ovf     = err_ovf_r;
    assign err_orphan  = err_orphan_r;
    assign err_tmo     = err_tmo_r;

endmodule

// File: tb/tb_mpmc9_read_return.sv
// Self-checking bench for mpmc9_read_return: table-driven cycle vectors plus
// hand-written sequences, with a scoreboard of expected acks (cycle, channel,
// data) compared by a monitor whenever ch_ack is nonzero.
module tb_mpmc9_read_return;

    localparam int TB_TMO = 1023;

    logic          clk = 1'b0;
    logic          rstn;
    logic          tag_wr;
    logic [2:0]    tag_ch;
    logic [1:0]    tag_beats;
    logic          tag_full;
    logic          rd_valid;
    logic [127:0]  rd_data;
    logic [1023:0] ch_rdat;
    logic [7:0]    ch_ack;
    logic [4:0]    outstanding;
    logic          err_clr;
    logic          err_ovf, err_orphan, err_tmo;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic tag_wr; logic [2:0] tag_ch; logic [1:0] tag_beats;
        logic rd_valid; logic [127:0] rd_data; logic err_clr;
        logic exp_ack; logic [2:0] exp_ch;
        logic [4:0] exp_out; logic exp_full; logic exp_ovf; logic exp_orphan;
    } vec_t;

    typedef struct { int cyc; logic [2:0] ch; logic [127:0] data; } exp_t;

    exp_t sb_q[$];
    vec_t tbl[18];

    mpmc9_read_return #(.TAG_DEPTH(16), .TMO_CYC(TB_TMO)) dut (
        .clk(clk), .rstn(rstn), .tag_wr(tag_wr), .tag_ch(tag_ch),
        .tag_beats(tag_beats), .tag_full(tag_full), .rd_valid(rd_valid),
        .rd_data(rd_data), .ch_rdat(ch_rdat), .ch_ack(ch_ack),
        .outstanding(outstanding), .err_clr(err_clr), .err_ovf(err_ovf),
        .err_orphan(err_orphan), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic tw, input logic [2:0] tc, input logic [1:0] tb,
                                input logic rv, input logic [127:0] rdat, input logic clr,
                                input logic ea, input logic [2:0] ech, input logic [4:0] eo,
                                input logic ef, input logic eov, input logic eor);
        vec_t v;
        v.tag_wr = tw; v.tag_ch = tc; v.tag_beats = tb; v.rd_valid = rv;
        v.rd_data = rdat; v.err_clr = clr; v.exp_ack = ea; v.exp_ch = ech;
        v.exp_out = eo; v.exp_full = ef; v.exp_ovf = eov; v.exp_orphan = eor;
        return v;
    endfunction

    // Drive one cycle (called at posedge+1), then check registered status
    task automatic apply(input vec_t v);
        tag_wr = v.tag_wr; tag_ch = v.tag_ch; tag_beats = v.tag_beats;
        rd_valid = v.rd_valid; rd_data = v.rd_data; err_clr = v.err_clr;
        if (v.exp_ack) sb_q.push_back('{cyc + 1, v.exp_ch, v.rd_data});
        @(posedge clk); #1;
        tag_wr = 1'b0; rd_valid = 1'b0; err_clr = 1'b0;
        chk("outstanding", 128'(outstanding), 128'(v.exp_out));
        chk("tag_full", 128'(tag_full), 128'(v.exp_full));
        chk("err_ovf", 128'(err_ovf), 128'(v.exp_ovf));
        chk("err_orphan", 128'(err_orphan), 128'(v.exp_orphan));
        chk("err_tmo", 128'(err_tmo), 128'd0);
    endtask

    // Monitor: every ack must match the next scoreboard entry exactly
    always @(negedge clk) begin
        if (rstn && ch_ack != 8'd0) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got %0h expected none (cycle %0d)", ch_ack, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_cycle", 128'(cyc), 128'(e.cyc));
                chk("ack_onehot", 128'(ch_ack), 128'(8'd1 << e.ch));
                chk("ch_rdat", ch_rdat[int'(e.ch)*128 +: 128], e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; tag_wr = 1'b0; tag_ch = 3'd0; tag_beats = 2'd0;
        rd_valid = 1'b0; rd_data = 128'd0; err_clr = 1'b0;

        //               tw  ch    bt    rv  data                                        clr  ea  ech  out  f  ov or
        tbl[0]  = mk(1'b1, 3'd3, 2'd0, 1'b0, 128'd0,                                     1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0003, 1'b0, 1'b1, 3'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 3'd1, 2'd3, 1'b0, 128'd0,                                     1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 3'd6, 2'd1, 1'b0, 128'd0,                                     1'b0, 1'b0, 3'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hD0D0_0000_0000_0000_0000_0000_0000_00D0, 1'b0, 1'b1, 3'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hD1D1_0000_0000_0000_0000_0000_0000_00D1, 1'b0, 1'b1, 3'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hD2D2_0000_0000_0000_0000_0000_0000_00D2, 1'b0, 1'b1, 3'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hD3D3_0000_0000_0000_0000_0000_0000_00D3, 1'b0, 1'b1, 3'd1, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hD4D4_0000_0000_0000_0000_0000_0000_00D4, 1'b0, 1'b1, 3'd6, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hD5D5_0000_0000_0000_0000_0000_0000_00D5, 1'b0, 1'b1, 3'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 3'd4, 2'd0, 1'b0, 128'd0,                                     1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 3'd7, 2'd0, 1'b1, 128'hE0E0_0000_0000_0000_0000_0000_0000_00E0, 1'b0, 1'b1, 3'd4, 5'd1, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hE1E1_0000_0000_0000_0000_0000_0000_00E1, 1'b0, 1'b1, 3'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 3'd2, 2'd0, 1'b1, 128'h0BAD_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        tbl[14] = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hF0F0_0000_0000_0000_0000_0000_0000_00F2, 1'b0, 1'b1, 3'd2, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 3'd0, 2'd0, 1'b0, 128'd0,                                     1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 3'd0, 2'd0, 1'b1, 128'h0BAD_0000_0000_0000_0000_0000_0000_0001, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tbl[17] = mk(1'b0, 3'd0, 2'd0, 1'b0, 128'd0,                                     1'b1, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outstanding", 128'(outstanding), 128'd0);
        chk("rst_full", 128'(tag_full), 128'd0);
        chk("rst_ack", 128'(ch_ack), 128'd0);
        chk("rst_rdat_or", 128'(|ch_rdat), 128'd0);
        chk("rst_errs", 128'({err_ovf, err_orphan, err_tmo}), 128'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors: single beat, multi-beat across tag boundary,
        // push+pop same cycle, orphan with same-cycle push, clear priority
        for (int i = 0; i < 18; i++) apply(tbl[i]);

        // Fill to full, overflow, clear, push-while-full with a pop, drain
        for (int i = 0; i < 16; i++)
            apply(mk(1'b1, 3'(i), 2'd0, 1'b0, 128'd0, 1'b0, 1'b0, 3'd0, 5'(i + 1), i == 15, 1'b0, 1'b0));
        apply(mk(1'b1, 3'd5, 2'd0, 1'b0, 128'd0, 1'b0, 1'b0, 3'd0, 5'd16, 1'b1, 1'b1, 1'b0));
        apply(mk(1'b0, 3'd0, 2'd0, 1'b0, 128'd0, 1'b1, 1'b0, 3'd0, 5'd16, 1'b1, 1'b0, 1'b0));
        apply(mk(1'b1, 3'd7, 2'd0, 1'b1, 128'h1000, 1'b0, 1'b1, 3'd0, 5'd15, 1'b0, 1'b1, 1'b0));
        apply(mk(1'b0, 3'd0, 2'd0, 1'b0, 128'd0, 1'b1, 1'b0, 3'd0, 5'd15, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i < 16; i++)
            apply(mk(1'b0, 3'd0, 2'd0, 1'b1, 128'h1000 + 128'(i), 1'b0, 1'b1, 3'(i), 5'(15 - i), 1'b0, 1'b0, 1'b0));

        // Reset mid-burst after 2 of 4 beats
        apply(mk(1'b1, 3'd1, 2'd3, 1'b0, 128'd0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hAA01, 1'b0, 1'b1, 3'd1, 5'd1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hAA02, 1'b0, 1'b1, 3'd1, 5'd1, 1'b0, 1'b0, 1'b0));
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_outstanding", 128'(outstanding), 128'd0);
        chk("mid_rst_ack", 128'(ch_ack), 128'd0);
        chk("mid_rst_rdat_or", 128'(|ch_rdat), 128'd0);
        chk("mid_rst_full", 128'(tag_full), 128'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        apply(mk(1'b1, 3'd0, 2'd0, 1'b0, 128'd0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hBB00, 1'b0, 1'b1, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0));

        // Idle timeout (or its absence) with one tag pending
        apply(mk(1'b1, 3'd5, 2'd0, 1'b0, 128'd0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0));
        repeat (TB_TMO - 1) @(posedge clk);
        #1;
        chk("tmo_before_out", 128'(outstanding), 128'd1);
        chk("tmo_before_flag", 128'(err_tmo), 128'd0);
        @(posedge clk); #1;
`ifdef MPMC9_RRET_TIMEOUT_EN
        chk("tmo_after_out", 128'(outstanding), 128'd0);
        chk("tmo_after_flag", 128'(err_tmo), 128'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("tmo_clr", 128'(err_tmo), 128'd0);
`else
        chk("tmo_after_out", 128'(outstanding), 128'd1);
        chk("tmo_after_flag", 128'(err_tmo), 128'd0);
        apply(mk(1'b0, 3'd0, 2'd0, 1'b1, 128'hCC05, 1'b0, 1'b1, 3'd5, 5'd0, 1'b0, 1'b0, 1'b0));
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
